// File: rtl/shift_sched_if.sv
// rtl/shift_sched_if.sv - request/response bundle between the two requesters, the consumer and shift_sched
interface shift_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_dataA;
  logic [31:0] req1_dataA;
  logic [4:0]  req0_dataB;
  logic [4:0]  req1_dataB;
  logic [5:0]  req0_Signal;
  logic [5:0]  req1_Signal;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_dataOut;
  logic        rsp_err;

  modport master (
    output req_valid, req0_dataA, req1_dataA, req0_dataB, req1_dataB,
           req0_Signal, req1_Signal, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_dataOut, rsp_err
  );

  modport slave (
    input  req_valid, req0_dataA, req1_dataA, req0_dataB, req1_dataB,
           req0_Signal, req1_Signal, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_dataOut, rsp_err
  );
endinterface

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - two-port arbiter/sequencer for a shared left-only barrel shifter
// Define SHIFT_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module shift_sched #(
  parameter logic [5:0] SLL = 6'b000000,
  parameter logic [5:0] SRL = 6'b000010,
  parameter logic [5:0] SRA = 6'b000011
) (
  input  logic              clk,
  input  logic              reset,
  shift_sched_if.slave      bus,
  output logic [31:0]       sh_dataA,
  output logic [4:0]        sh_dataB,
  output logic [5:0]        sh_Signal,
  output logic              sh_reset,
  input  logic [31:0]       sh_dataOut
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    for (int i = 0; i < 32; i++) rev32[i] = v[31-i];
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [4:0]  amt_q, amt_d;
  logic [1:0]  kind_q, kind_d;
  logic        id_q, id_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;

  logic        grant;
  logic [1:0]  ready;
  logic        fire;
  logic [31:0] sel_a;
  logic [4:0]  sel_b;
  logic [5:0]  sel_sig;
  logic [1:0]  sel_kind;

`ifdef SHIFT_SCHED_RR_EN
  // rr_q names the requester preferred when both are valid
  logic rr_q, rr_d;

  always_comb begin
    grant = (&bus.req_valid) ? rr_q : ~bus.req_valid[0];
    rr_d  = fire ? ~grant : rr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`else
  always_comb grant = ~bus.req_valid[0];
`endif

  always_comb begin
    ready = 2'b00;
    if (state_q == S_IDLE && reset)
      ready = grant ? {bus.req_valid[1], 1'b0} : {1'b0, bus.req_valid[0]};
    fire    = |ready;
    sel_a   = grant ? bus.req1_dataA  : bus.req0_dataA;
    sel_b   = grant ? bus.req1_dataB  : bus.req0_dataB;
    sel_sig = grant ? bus.req1_Signal : bus.req0_Signal;
    if (sel_sig == SLL)      sel_kind = K_SLL;
    else if (sel_sig == SRL) sel_kind = K_SRL;
    else if (sel_sig == SRA) sel_kind = K_SRA;
    else                     sel_kind = K_ERR;
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    amt_d   = amt_q;
    kind_d  = kind_q;
    id_d    = id_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          opa_d   = sel_a;
          amt_d   = sel_b;
          kind_d  = sel_kind;
          id_d    = grant;
          err_d   = (sel_kind == K_ERR);
          state_d = S_PASS1;
        end
      end
      S_PASS1: begin
        if (kind_q == K_ERR)      res_d = 32'h0;
        else if (kind_q == K_SLL) res_d = sh_dataOut;
        else                      res_d = rev32(sh_dataOut);
        // negative SRA needs a second pass to fill the vacated top bits with ones
        state_d = (kind_q == K_SRA && opa_q[31] && amt_q != 5'd0) ? S_PASS2 : S_DONE;
      end
      S_PASS2: begin
        res_d   = res_q | ~rev32(sh_dataOut);
        state_d = S_DONE;
      end
      default: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    sh_dataA = 32'h0;
    sh_dataB = 5'd0;
    if (state_q == S_PASS1 && kind_q != K_ERR) begin
      sh_dataA = (kind_q == K_SLL) ? opa_q : rev32(opa_q);
      sh_dataB = amt_q;
    end else if (state_q == S_PASS2) begin
      sh_dataA = 32'hFFFF_FFFF;
      sh_dataB = amt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      opa_q   <= 32'h0;
      amt_q   <= 5'd0;
      kind_q  <= K_SLL;
      id_q    <= 1'b0;
      res_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      amt_q   <= amt_d;
      kind_q  <= kind_d;
      id_q    <= id_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign sh_Signal       = SLL;
  assign sh_reset        = ~reset;
  assign bus.req_ready   = ready;
  assign bus.rsp_valid   = (state_q == S_DONE);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_dataOut = res_q;
  assign bus.rsp_err     = err_q;

endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - directed self-checking bench for shift_sched with a behavioural left shifter
module tb_shift_sched;
  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] BAD = 6'b100000;

  logic        clk;
  logic        reset;
  logic [31:0] sh_dataA;
  logic [4:0]  sh_dataB;
  logic [5:0]  sh_Signal;
  logic        sh_reset;
  logic [31:0] sh_dataOut;

  int errors = 0;
  int checks = 0;

  shift_sched_if ifc ();

  shift_sched dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (ifc),
    .sh_dataA   (sh_dataA),
    .sh_dataB   (sh_dataB),
    .sh_Signal  (sh_Signal),
    .sh_reset   (sh_reset),
    .sh_dataOut (sh_dataOut)
  );

  assign sh_dataOut = sh_dataA << sh_dataB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request; lat counts rising edges from the cycle req_ready is seen until rsp_valid (-1 on timeout).
  task automatic run_op(input int id, input logic [31:0] a, input logic [4:0] b, input logic [5:0] sig,
                        input bit consume, output int lat, output logic [31:0] data, output logic rid,
                        output logic err, output logic [31:0] p1_a, output logic [4:0] p1_b);
    int w;
    @(negedge clk);
    if (id == 0) begin
      ifc.req0_dataA = a; ifc.req0_dataB = b; ifc.req0_Signal = sig; ifc.req_valid = 2'b01;
    end else begin
      ifc.req1_dataA = a; ifc.req1_dataB = b; ifc.req1_Signal = sig; ifc.req_valid = 2'b10;
    end
    #1;
    w = 0;
    while (!ifc.req_ready[id] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    lat  = -1;
    p1_a = 32'hDEAD_BEEF;
    p1_b = 5'h1F;
    if (ifc.req_ready[id]) begin
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk); #1;
        if (k == 1) begin
          ifc.req_valid = 2'b00;
          p1_a = sh_dataA;
          p1_b = sh_dataB;
        end
        if (ifc.rsp_valid) begin
          lat = k;
          break;
        end
      end
    end
    ifc.req_valid = 2'b00;
    data = ifc.rsp_dataOut;
    rid  = ifc.rsp_id;
    err  = ifc.rsp_err;
    if (consume && lat > 0) begin
      ifc.rsp_ready = 1'b1;
      @(posedge clk); #1;
      ifc.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ifc.req_valid = 2'b11;
    repeat (2) @(negedge clk);
    checks++; if (ifc.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", ifc.req_ready); end
    checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", ifc.rsp_valid); end
    checks++; if (ifc.rsp_dataOut !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", ifc.rsp_dataOut); end
    checks++; if (sh_reset !== 1'b1) begin errors++; $display("FAIL reset_sh_reset got %b exp 1", sh_reset); end
    checks++; if (sh_Signal !== SLL) begin errors++; $display("FAIL reset_sh_signal got %b exp %b", sh_Signal, SLL); end
    checks++; if ({sh_dataA, sh_dataB} !== 37'h0) begin errors++; $display("FAIL reset_sh_inputs got %h/%h exp 0/0", sh_dataA, sh_dataB); end
    ifc.req_valid = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sh_reset !== 1'b0) begin errors++; $display("FAIL run_sh_reset got %b exp 0", sh_reset); end
  endtask

  task automatic test_sll();
    int lat; logic [31:0] d, pa; logic rid, err; logic [4:0] pb;
    run_op(0, 32'h0000_0001, 5'd4, SLL, 1'b1, lat, d, rid, err, pa, pb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sll_latency got %0d exp 2", lat); end
    checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL sll_data got %h exp 00000010", d); end
    checks++; if ({rid, err} !== 2'b00) begin errors++; $display("FAIL sll_id_err got %b%b exp 00", rid, err); end
    checks++; if ({pa, pb} !== {32'h0000_0001, 5'd4}) begin errors++; $display("FAIL sll_pass1_sh got %h/%0d exp 00000001/4", pa, pb); end
  endtask

  task automatic test_srl();
    int lat; logic [31:0] d, pa; logic rid, err; logic [4:0] pb;
    run_op(1, 32'h8000_0000, 5'd31, SRL, 1'b1, lat, d, rid, err, pa, pb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL srl_latency got %0d exp 2", lat); end
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL srl_data got %h exp 00000001", d); end
    checks++; if ({rid, err} !== 2'b10) begin errors++; $display("FAIL srl_id_err got %b%b exp 10", rid, err); end
    checks++; if (pa !== 32'h0000_0001) begin errors++; $display("FAIL srl_pass1_rev got %h exp 00000001", pa); end
  endtask

  task automatic test_sra();
    int lat; logic [31:0] d, pa; logic rid, err; logic [4:0] pb;
    run_op(0, 32'h8000_0000, 5'd4, SRA, 1'b1, lat, d, rid, err, pa, pb);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sra_neg_latency got %0d exp 3", lat); end
    checks++; if (d !== 32'hF800_0000) begin errors++; $display("FAIL sra_neg_data got %h exp f8000000", d); end
    run_op(1, 32'h7000_0000, 5'd4, SRA, 1'b1, lat, d, rid, err, pa, pb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sra_pos_latency got %0d exp 2", lat); end
    checks++; if (d !== 32'h0700_0000) begin errors++; $display("FAIL sra_pos_data got %h exp 07000000", d); end
    run_op(0, 32'hFFFF_FFF0, 5'd0, SRA, 1'b1, lat, d, rid, err, pa, pb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sra_zero_latency got %0d exp 2", lat); end
    checks++; if (d !== 32'hFFFF_FFF0) begin errors++; $display("FAIL sra_zero_data got %h exp fffffff0", d); end
  endtask

  task automatic test_error();
    int lat; logic [31:0] d, pa; logic rid, err; logic [4:0] pb;
    run_op(0, 32'h1234_5678, 5'd5, BAD, 1'b1, lat, d, rid, err, pa, pb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL err_latency got %0d exp 2", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got %b exp 1", err); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_data got %h exp 0", d); end
    checks++; if ({pa, pb} !== 37'h0) begin errors++; $display("FAIL err_sh_inputs got %h/%0d exp 0/0", pa, pb); end
  endtask

  task automatic test_backpressure_reset();
    int lat, w; logic [31:0] d, pa; logic rid, err; logic [4:0] pb; bit seen;
    run_op(1, 32'h0000_00F0, 5'd8, SLL, 1'b0, lat, d, rid, err, pa, pb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL bp_latency got %0d exp 2", lat); end
    ifc.req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err, ifc.rsp_dataOut, ifc.req_ready} !== {3'b110, 32'h0000_F000, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold_c%0d got v=%b id=%b e=%b d=%h rdy=%b exp v=1 id=1 e=0 d=0000f000 rdy=00",
                 c, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err, ifc.rsp_dataOut, ifc.req_ready);
      end
    end
    ifc.req_valid = 2'b00;
    ifc.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
    checks++; if (ifc.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", ifc.rsp_valid); end

    @(negedge clk);
    ifc.req1_dataA = 32'h8000_0000; ifc.req1_dataB = 5'd3; ifc.req1_Signal = SRA; ifc.req_valid = 2'b10;
    #1;
    w = 0;
    while (!ifc.req_ready[1] && w < 20) begin @(negedge clk); #1; w++; end
    checks++; if (ifc.req_ready !== 2'b10) begin errors++; $display("FAIL abort_grant got %b exp 10", ifc.req_ready); end
    @(posedge clk); #1;
    ifc.req_valid = 2'b00;
    reset = 1'b0;
    #1;
    checks++;
    if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err, ifc.rsp_dataOut, ifc.req_ready, sh_dataA, sh_dataB, sh_reset, sh_Signal}
        !== {3'b000, 32'h0, 2'b00, 32'h0, 5'd0, 1'b1, SLL}) begin
      errors++;
      $display("FAIL abort_outputs got v=%b id=%b e=%b d=%h rdy=%b sha=%h shb=%0d shr=%b exp all reset values",
               ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err, ifc.rsp_dataOut, ifc.req_ready, sh_dataA, sh_dataB, sh_reset);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (ifc.rsp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_rsp got rsp_valid seen=%b exp 0", seen); end
  endtask

  task automatic test_arbitration();
    logic ids [2];
    int n;
    logic exp1;
`ifdef SHIFT_SCHED_RR_EN
    exp1 = 1'b1;
`else
    exp1 = 1'b0;
`endif
    ids[0] = 1'bx; ids[1] = 1'bx;
    @(negedge clk);
    ifc.req0_dataA = 32'h0000_0003; ifc.req0_dataB = 5'd1; ifc.req0_Signal = SLL;
    ifc.req1_dataA = 32'h0000_0100; ifc.req1_dataB = 5'd4; ifc.req1_Signal = SRL;
    ifc.req_valid = 2'b11;
    ifc.rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge clk);
      if (ifc.rsp_valid) begin
        ids[n] = ifc.rsp_id;
        n++;
        if (n == 2) ifc.req_valid = 2'b00;
      end
    end
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 2'b00;
    checks++; if (n !== 2) begin errors++; $display("FAIL arb_count got %0d exp 2", n); end
    checks++; if (ids[0] !== 1'b0) begin errors++; $display("FAIL arb_first got %b exp 0", ids[0]); end
    checks++; if (ids[1] !== exp1) begin errors++; $display("FAIL arb_second got %b exp %b", ids[1], exp1); end
  endtask

  initial begin
    reset = 1'b0;
    ifc.req_valid = 2'b00;
    ifc.req0_dataA = 32'h0; ifc.req0_dataB = 5'd0; ifc.req0_Signal = SLL;
    ifc.req1_dataA = 32'h0; ifc.req1_dataB = 5'd0; ifc.req1_Signal = SLL;
    ifc.rsp_ready = 1'b0;
    test_reset();
    test_sll();
    test_srl();
    test_sra();
    test_error();
    test_backpressure_reset();
    test_arbitration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
